gray_code_converter: RTL and testbench

Parametrised, pipelined bidirectional Gray-code converter with a valid/ready stream interface on both sides. Each transaction carries its own mode bit, selecting binary→Gray or Gray→binary conversion. It sits between the counter/pointer logic and the consumers that need the other encoding, such as FIFO pointer crossings, encoder readouts and debug taps. An optional adjacency checker flags Gray sequences that change more than one bit between consecutive transactions.

---
 rtl/gray_conv_pkg.sv | 29 ++
 rtl/gray_adj_checker.sv | 50 +++++
 rtl/gray_code_converter.sv | 139 +++++++++++++
 tb/tb_gray_code_converter.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gray_conv_pkg.sv
// Shared types and conversion helpers for gray_code_converter.
// Helpers operate on a GRAY_MAX_WIDTH word; callers zero-extend and truncate.
package gray_conv_pkg;

  typedef enum logic {
    MODE_B2G = 1'b0,
    MODE_G2B = 1'b1
  } gray_mode_t;

  localparam int GRAY_CONV_LATENCY = 2;
  localparam int GRAY_MAX_WIDTH    = 256;

  typedef logic [GRAY_MAX_WIDTH-1:0] gray_word_t;

  // Zero upper bits leave both conversions exact for any narrower width.
  function automatic gray_word_t bin2gray(input gray_word_t bin);
    return bin ^ (bin >> 1);
  endfunction

  function automatic gray_word_t gray2bin(input gray_word_t gray);
    gray_word_t bin;
    bin = gray;
    for (int sh = 1; sh < GRAY_MAX_WIDTH; sh = sh * 2) begin
      bin = bin ^ (bin >> sh);
    end
    return bin;
  endfunction

endpackage

// File: rtl/gray_adj_checker.sv
// Flags Gray-domain transactions that differ from the previous one by more
// than one bit; holds the previous value and a sticky error flag.
module gray_adj_checker
  import gray_conv_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] gray_cur,
  output logic             adj_err,
  output logic             adj_err_sticky
);

  logic [WIDTH-1:0] prev_q, prev_d;
  logic             have_prev_q, have_prev_d;
  logic             sticky_q, sticky_d;
  logic [WIDTH-1:0] diff;

  always_comb begin
    diff    = gray_cur ^ prev_q;
    // More than one bit set <=> clearing the lowest set bit leaves something.
    adj_err = have_prev_q && ((diff & (diff - WIDTH'(1))) != '0);

    prev_d      = prev_q;
    have_prev_d = have_prev_q;
    sticky_d    = sticky_q;
    if (load) begin
      prev_d      = gray_cur;
      have_prev_d = 1'b1;
      sticky_d    = sticky_q | adj_err;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev_q      <= '0;
      have_prev_q <= 1'b0;
      sticky_q    <= 1'b0;
    end else begin
      prev_q      <= prev_d;
      have_prev_q <= have_prev_d;
      sticky_q    <= sticky_d;
    end
  end

  assign adj_err_sticky = sticky_q;

endmodule

// File: rtl/gray_code_converter.sv
// Two-stage valid/ready binary<->Gray converter (WIDTH 2..GRAY_MAX_WIDTH).
// Define GRAY_CONV_ADJ_CHECK_EN to add the Gray adjacency checker and its ports.
module gray_code_converter
  import gray_conv_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_mode,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_mode,
  output logic [WIDTH-1:0] out_data
`ifdef GRAY_CONV_ADJ_CHECK_EN
  ,
  output logic             out_adj_err,
  output logic             adj_err_sticky
`endif
);

  logic             s1_valid_q, s1_valid_d;
  gray_mode_t       s1_mode_q, s1_mode_d;
  logic [WIDTH-1:0] s1_data_q, s1_data_d;

  logic             out_valid_q, out_valid_d;
  gray_mode_t       out_mode_q, out_mode_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;

  logic             s2_adv, s1_adv, s2_load, in_fire;
  logic [WIDTH-1:0] conv_data;

  // Ready flows backwards combinationally from out_ready; no skid buffer.
  assign s2_adv   = !out_valid_q || out_ready;
  assign s1_adv   = !s1_valid_q || s2_adv;
  assign in_ready = s1_adv && rst_n;
  assign in_fire  = in_valid && in_ready;
  assign s2_load  = s2_adv && s1_valid_q;

  always_comb begin
    if (s1_mode_q == MODE_G2B) begin
      conv_data = WIDTH'(gray2bin(gray_word_t'(s1_data_q)));
    end else begin
      conv_data = WIDTH'(bin2gray(gray_word_t'(s1_data_q)));
    end
  end

  // NOTE: every variable gets a default before the conditionals, otherwise
  // always_comb would infer a latch on the hold path.
  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_mode_d   = s1_mode_q;
    s1_data_d   = s1_data_q;
    out_valid_d = out_valid_q;
    out_mode_d  = out_mode_q;
    out_data_d  = out_data_q;

    if (s1_adv) begin
      s1_valid_d = in_fire;
    end
    if (in_fire) begin
      s1_mode_d = gray_mode_t'(in_mode);
      s1_data_d = in_data;
    end

    if (s2_adv) begin
      out_valid_d = s1_valid_q;
    end
    if (s2_load) begin
      out_mode_d = s1_mode_q;
      out_data_d = conv_data;
    end
  end

  // NOTE: reset is synchronous and checked first; state updates use <= so
  // every flop samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_mode_q   <= MODE_B2G;
      s1_data_q   <= '0;
      out_valid_q <= 1'b0;
      out_mode_q  <= MODE_B2G;
      out_data_q  <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_mode_q   <= s1_mode_d;
      s1_data_q   <= s1_data_d;
      out_valid_q <= out_valid_d;
      out_mode_q  <= out_mode_d;
      out_data_q  <= out_data_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_mode  = out_mode_q;
  assign out_data  = out_data_q;

`ifdef GRAY_CONV_ADJ_CHECK_EN
  logic             chk_err;
  logic             out_adj_err_q, out_adj_err_d;
  logic [WIDTH-1:0] s1_gray;

  // Gray-domain view of the S1 transaction: result for B2G, input for G2B.
  assign s1_gray = (s1_mode_q == MODE_B2G) ? conv_data : s1_data_q;

  gray_adj_checker #(
    .WIDTH (WIDTH)
  ) u_adj_checker (
    .clk            (clk),
    .rst_n          (rst_n),
    .load           (s2_load),
    .gray_cur       (s1_gray),
    .adj_err        (chk_err),
    .adj_err_sticky (adj_err_sticky)
  );

  always_comb begin
    out_adj_err_d = out_adj_err_q;
    if (s2_load) begin
      out_adj_err_d = chk_err;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_adj_err_q <= 1'b0;
    end else begin
      out_adj_err_q <= out_adj_err_d;
    end
  end

  assign out_adj_err = out_adj_err_q;
`endif

endmodule

// File: tb/tb_gray_code_converter.sv
// Self-checking bench for gray_code_converter (WIDTH=8): table vectors plus
// directed latency, backpressure, reset and adjacency sequences.
module tb_gray_code_converter;
  import gray_conv_pkg::*;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic             in_mode = 1'b0;
  logic [WIDTH-1:0] in_data = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic             out_mode;
  logic [WIDTH-1:0] out_data;
`ifdef GRAY_CONV_ADJ_CHECK_EN
  logic             out_adj_err;
  logic             adj_err_sticky;
`endif

  gray_code_converter #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mode   (in_mode),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_mode  (out_mode),
    .out_data  (out_data)
`ifdef GRAY_CONV_ADJ_CHECK_EN
    ,
    .out_adj_err    (out_adj_err),
    .adj_err_sticky (adj_err_sticky)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       mode;
    logic [7:0] data;
    logic       adj;
    logic       sticky;
  } exp_t;

  typedef struct {
    logic       mode;
    logic [7:0] data;
    logic [7:0] exp;
  } vec_t;

  exp_t       sb_q[$];
  logic [7:0] out_log[$];
  logic       adj_log[$];
  exp_t       mon_e;

  int         n_checks = 0;
  int         n_pass   = 0;
  int         stalls   = 0;
  logic [7:0] drv_exp  = '0;

  logic       m_have_prev = 1'b0;
  logic [7:0] m_prev      = '0;
  logic       m_sticky    = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  function automatic logic [7:0] m_b2g(input logic [7:0] b);
    logic [7:0] g;
    g[7] = b[7];
    for (int i = 0; i < 7; i++) g[i] = b[i+1] ^ b[i];
    return g;
  endfunction

  function automatic logic [7:0] m_g2b(input logic [7:0] g);
    logic [7:0] b;
    b[7] = g[7];
    for (int i = 6; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  // Scoreboard: pop on each output transfer, push on each input transfer.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          fail_now("unexpected_output");
        end else begin
          mon_e = sb_q.pop_front();
          check("out_data", 32'(out_data), 32'(mon_e.data));
          check("out_mode", 32'(out_mode), 32'(mon_e.mode));
`ifdef GRAY_CONV_ADJ_CHECK_EN
          check("out_adj_err", 32'(out_adj_err), 32'(mon_e.adj));
          check("adj_err_sticky", 32'(adj_err_sticky), 32'(mon_e.sticky));
          adj_log.push_back(out_adj_err);
`endif
        end
        out_log.push_back(out_data);
      end
      if (in_valid && in_ready) begin
        logic [7:0] gdom;
        logic       err;
        gdom        = in_mode ? in_data : m_b2g(in_data);
        err         = m_have_prev && ($countones(gdom ^ m_prev) > 1);
        m_sticky    = m_sticky | err;
        m_prev      = gdom;
        m_have_prev = 1'b1;
        sb_q.push_back('{mode: in_mode, data: drv_exp, adj: err, sticky: m_sticky});
      end
    end
  end

  // All main-thread tasks start and end at posedge+1.
  task automatic send(input logic mode, input logic [7:0] data, input logic [7:0] exp);
    bit accepted = 0;
    int waits = 0;
    in_valid = 1'b1;
    in_mode  = mode;
    in_data  = data;
    drv_exp  = exp;
    while (!accepted && waits < 20) begin
      @(negedge clk);
      if (in_ready) accepted = 1;
      else waits++;
      @(posedge clk);
      #1;
    end
    stalls += waits;
    if (!accepted) fail_now("send_timeout");
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 64 && sb_q.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    if (sb_q.size() != 0) fail_now("drain_timeout");
  endtask

  task automatic do_reset(input int cycles);
    rst_n    = 1'b0;
    in_valid = 1'b0;
    sb_q.delete();
    m_have_prev = 1'b0;
    m_sticky    = 1'b0;
    #1;
    check("rst_in_ready_low", 32'(in_ready), 32'd0);
    repeat (cycles) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_mode", 32'(out_mode), 32'd0);
    check("rst_in_ready_held", 32'(in_ready), 32'd0);
`ifdef GRAY_CONV_ADJ_CHECK_EN
    check("rst_out_adj_err", 32'(out_adj_err), 32'd0);
    check("rst_adj_err_sticky", 32'(adj_err_sticky), 32'd0);
`endif
    rst_n = 1'b1;
    #1;
    check("rst_in_ready_release", 32'(in_ready), 32'd1);
  endtask

  // Two register stages: output visible two edges after the input is presented.
  task automatic latency_probe(input logic mode, input logic [7:0] data, input logic [7:0] exp);
    send(mode, data, exp);
    idle();
    check("lat_not_early", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    check("lat_valid", 32'(out_valid), 32'd1);
    check("lat_data", 32'(out_data), 32'(exp));
    drain();
  endtask

  vec_t       tbl[12];
  logic [7:0] gray_seen[256];
  logic [7:0] bp_vals[3];
  int         bp_acc;
  int         bp_idx;

  initial begin
    tbl[0]  = '{mode: 1'b0, data: 8'h0B, exp: 8'h0E};
    tbl[1]  = '{mode: 1'b1, data: 8'h0E, exp: 8'h0B};
    tbl[2]  = '{mode: 1'b0, data: 8'hFF, exp: 8'h80};
    tbl[3]  = '{mode: 1'b1, data: 8'h80, exp: 8'hFF};
    tbl[4]  = '{mode: 1'b0, data: 8'h00, exp: 8'h00};
    tbl[5]  = '{mode: 1'b1, data: 8'h00, exp: 8'h00};
    tbl[6]  = '{mode: 1'b0, data: 8'h02, exp: 8'h03};
    tbl[7]  = '{mode: 1'b1, data: 8'h03, exp: 8'h02};
    tbl[8]  = '{mode: 1'b0, data: 8'h55, exp: 8'h7F};
    tbl[9]  = '{mode: 1'b1, data: 8'hFF, exp: 8'hAA};
    tbl[10] = '{mode: 1'b0, data: 8'h01, exp: 8'h01};
    tbl[11] = '{mode: 1'b1, data: 8'h01, exp: 8'h01};
    bp_vals[0] = 8'h01;
    bp_vals[1] = 8'h02;
    bp_vals[2] = 8'h03;

    // Power-on reset.
    repeat (2) @(posedge clk);
    #1;
    check("por_out_valid", 32'(out_valid), 32'd0);
    check("por_out_data", 32'(out_data), 32'd0);
    check("por_in_ready", 32'(in_ready), 32'd0);
    rst_n = 1'b1;
    #1;
    check("por_in_ready_release", 32'(in_ready), 32'd1);

    latency_probe(1'b0, 8'h0B, 8'h0E);

    // Back-to-back table with alternating modes.
    stalls = 0;
    for (int i = 0; i < 12; i++) send(tbl[i].mode, tbl[i].data, tbl[i].exp);
    idle();
    check("table_no_bubble", 32'(stalls), 32'd0);
    drain();

    // Exhaustive: B2G pass, then feed DUT results back through G2B.
    out_log.delete();
    for (int x = 0; x < 256; x++) send(1'b0, 8'(x), m_b2g(8'(x)));
    idle();
    drain();
    check("exh_count", 32'(out_log.size()), 32'd256);
    for (int x = 0; x < 256; x++) gray_seen[x] = (x < out_log.size()) ? out_log[x] : 8'h00;
    for (int x = 0; x < 256; x++) send(1'b1, gray_seen[x], 8'(x));
    idle();
    drain();

    // Backpressure: 1, 2, 3 offered while out_ready is low.
    out_log.delete();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_mode   = 1'b0;
    bp_acc    = 0;
    bp_idx    = 0;
    for (int c = 0; c < 4; c++) begin
      in_data = bp_vals[bp_idx];
      drv_exp = m_b2g(bp_vals[bp_idx]);
      @(negedge clk);
      if (out_valid) check("bp_hold_data", 32'(out_data), 32'h01);
      if (in_ready) begin
        bp_acc++;
        if (bp_idx < 2) bp_idx++;
      end
      @(posedge clk);
      #1;
    end
    check("bp_accepted", 32'(bp_acc), 32'd2);
    check("bp_in_ready_low", 32'(in_ready), 32'd0);
    check("bp_out_valid", 32'(out_valid), 32'd1);
    check("bp_out_data", 32'(out_data), 32'h01);
    out_ready = 1'b1;
    #1;
    check("bp_recovery_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    @(posedge clk);
    #1;
    idle();
    drain();
    check("bp_out_count", 32'(out_log.size()), 32'd3);
    if (out_log.size() == 3) begin
      check("bp_order0", 32'(out_log[0]), 32'h01);
      check("bp_order1", 32'(out_log[1]), 32'h03);
      check("bp_order2", 32'(out_log[2]), 32'h02);
    end

    // Reset with two transactions in flight.
    out_ready = 1'b0;
    send(1'b0, 8'h05, m_b2g(8'h05));
    send(1'b0, 8'h06, m_b2g(8'h06));
    idle();
    do_reset(1);
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      check("rst_no_stale", 32'(out_valid), 32'd0);
    end
    latency_probe(1'b1, 8'h0E, 8'h0B);

`ifdef GRAY_CONV_ADJ_CHECK_EN
    do_reset(1);
    adj_log.delete();
    send(1'b1, 8'h00, 8'h00);
    send(1'b1, 8'h01, 8'h01);
    send(1'b1, 8'h03, 8'h02);
    send(1'b1, 8'h03, 8'h02);
    send(1'b1, 8'h00, 8'h00);
    idle();
    drain();
    check("adj_count", 32'(adj_log.size()), 32'd5);
    if (adj_log.size() == 5) begin
      check("adj_err0", 32'(adj_log[0]), 32'd0);
      check("adj_err1", 32'(adj_log[1]), 32'd0);
      check("adj_err2", 32'(adj_log[2]), 32'd0);
      check("adj_err3", 32'(adj_log[3]), 32'd0);
      check("adj_err4", 32'(adj_log[4]), 32'd1);
    end
    repeat (5) @(posedge clk);
    #1;
    check("adj_sticky_held", 32'(adj_err_sticky), 32'd1);
    do_reset(1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
